// File: rtl/ysyx_24100005_mem_arbiter_pkg.sv
// Shared types and default widths for the IFU/LSU memory-port arbiter.
package ysyx_24100005_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Owner encoding doubles as the bit index into the one-hot grant vector.
  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// Requester and memory-port bus bundle for the arbiter.
// slave: arbiter side; master: requesters plus memory model side.
interface ysyx_24100005_mem_arbiter_if
  import ysyx_24100005_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MASK_W = DEF_MASK_W
) ();

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_24100005_mem_arbiter_pick.sv
// Combinational grant selection between IFU and LSU.
// YSYX_24100005_ARB_RR_EN: round-robin on conflict; otherwise fixed LSU priority.
module ysyx_24100005_arb_pick
  import ysyx_24100005_mem_arbiter_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       en,
`ifdef YSYX_24100005_ARB_RR_EN
  input  owner_e     last_grant,
`endif
  output logic [1:0] grant_c
);

  // One-hot grant: bit 0 = IFU, bit 1 = LSU; nothing granted when disabled.
  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (ifu_valid && lsu_valid) begin
`ifdef YSYX_24100005_ARB_RR_EN
        if (last_grant == OWNER_LSU) grant_c = 2'b01;
        else                         grant_c = 2'b10;
`else
        grant_c = 2'b10;
`endif
      end else if (lsu_valid) begin
        grant_c = 2'b10;
      end else if (ifu_valid) begin
        grant_c = 2'b01;
      end
    end
  end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares the single memory port between IFU and LSU, one transaction in flight.
// YSYX_24100005_ARB_RR_EN: adds a last_grant register for round-robin arbitration.
module ysyx_24100005_mem_arbiter
  import ysyx_24100005_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MASK_W = DEF_MASK_W
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_24100005_mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              req_valid_q, req_valid_d;
  logic              ifu_resp_valid_q, ifu_resp_valid_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic [1:0]        grant_c;
  logic              pick_en_c;
`ifdef YSYX_24100005_ARB_RR_EN
  owner_e            last_grant_q, last_grant_d;
`endif

  // Grants only in IDLE and never while reset is held, so readies read 0 in reset.
  assign pick_en_c = (state_q == ST_IDLE) && rst;

  ysyx_24100005_arb_pick u_pick (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .en         (pick_en_c),
`ifdef YSYX_24100005_ARB_RR_EN
    .last_grant (last_grant_q),
`endif
    .grant_c    (grant_c)
  );

  // Requester and memory-side outputs.
  assign bus.ifu_req_ready  = grant_c[0];
  assign bus.lsu_req_ready  = grant_c[1];
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, request latch, response capture.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    req_valid_d      = 1'b0;
    ifu_resp_valid_d = 1'b0;
    lsu_resp_valid_d = 1'b0;
    ifu_rdata_d      = ifu_rdata_q;
    lsu_rdata_d      = lsu_rdata_q;
`ifdef YSYX_24100005_ARB_RR_EN
    last_grant_d     = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_c[1]) begin
          owner_d     = OWNER_LSU;
          addr_d      = bus.lsu_addr;
          wen_d       = bus.lsu_wen;
          wdata_d     = bus.lsu_wdata;
          wmask_d     = bus.lsu_wen ? bus.lsu_wmask : MASK_W'(0);
          req_valid_d = 1'b1;
          state_d     = ST_REQ;
`ifdef YSYX_24100005_ARB_RR_EN
          last_grant_d = OWNER_LSU;
`endif
        end else if (grant_c[0]) begin
          owner_d     = OWNER_IFU;
          addr_d      = bus.ifu_addr;
          wen_d       = 1'b0;
          wdata_d     = DATA_W'(0);
          wmask_d     = MASK_W'(0);
          req_valid_d = 1'b1;
          state_d     = ST_REQ;
`ifdef YSYX_24100005_ARB_RR_EN
          last_grant_d = OWNER_IFU;
`endif
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) state_d = ST_WAIT;
        else                   req_valid_d = 1'b1;
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = ST_RESP;
          if (owner_q == OWNER_IFU) begin
            ifu_resp_valid_d = 1'b1;
            ifu_rdata_d      = bus.mem_rdata;
            lsu_rdata_d      = DATA_W'(0);
          end else begin
            lsu_resp_valid_d = 1'b1;
            lsu_rdata_d      = bus.mem_rdata;
            ifu_rdata_d      = DATA_W'(0);
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; all clear in reset, owner parks on LSU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q          <= OWNER_LSU;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      req_valid_q      <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
`ifdef YSYX_24100005_ARB_RR_EN
      last_grant_q     <= OWNER_LSU;
`endif
    end else begin
      owner_q          <= owner_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      req_valid_q      <= req_valid_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      ifu_rdata_q      <= ifu_rdata_d;
      lsu_rdata_q      <= lsu_rdata_d;
`ifdef YSYX_24100005_ARB_RR_EN
      last_grant_q     <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter.
module tb_ysyx_24100005_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  ysyx_24100005_mem_arbiter_if bus ();

  ysyx_24100005_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference arbitration state: who was granted last (reset value LSU).
  bit last_lsu = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner by rule: single requester always wins; conflict resolved by policy.
  function automatic bit model_lsu_wins(input bit iv, input bit lv);
    if (iv && lv) begin
`ifdef YSYX_24100005_ARB_RR_EN
      return !last_lsu;
`else
      return 1'b1;
`endif
    end
    return lv;
  endfunction

  task automatic drive_idle();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic chk_busy(input string tag);
    chk({tag, "_ifu_ready"}, 32'(bus.ifu_req_ready), 32'd0);
    chk({tag, "_lsu_ready"}, 32'(bus.lsu_req_ready), 32'd0);
  endtask

  // One full transaction: handshake, REQ (ready after rdy_dly), WAIT (resp after rsp_dly), RESP.
  task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                        input bit lw, input logic [31:0] lwd, input logic [7:0] lm,
                        input int rdy_dly, input int rsp_dly, input bit spur,
                        input logic [31:0] rd, output bit w);
    logic [31:0] e_addr;
    bit          e_wen;
    logic [7:0]  e_mask;
    w = model_lsu_wins(iv, lv);
    @(negedge clk);
    bus.ifu_req_valid = iv; bus.ifu_addr = ia;
    bus.lsu_req_valid = lv; bus.lsu_addr = la; bus.lsu_wen = lw;
    bus.lsu_wdata = lwd; bus.lsu_wmask = lm;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = spur; bus.mem_rdata = $urandom;
    #1;
    chk("hs_ifu_ready", 32'(bus.ifu_req_ready), 32'(iv && !w));
    chk("hs_lsu_ready", 32'(bus.lsu_req_ready), 32'(w));
    chk("hs_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
    chk("hs_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
    chk("hs_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    last_lsu = w;
    e_addr = w ? la : ia;
    e_wen  = w && lw;
    e_mask = e_wen ? lm : 8'h00;
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk);
      if (w) begin
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = $urandom; bus.lsu_wdata = $urandom;
        bus.lsu_wmask = 8'($urandom); bus.lsu_wen = 1'($urandom);
      end else begin
        bus.ifu_req_valid = 1'b0; bus.ifu_addr = $urandom;
      end
      bus.mem_req_ready = (i == rdy_dly); bus.mem_resp_valid = spur;
      #1;
      chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("req_addr", bus.mem_addr, e_addr);
      chk("req_wen", 32'(bus.mem_wen), 32'(e_wen));
      chk("req_wmask", 32'(bus.mem_wmask), 32'(e_mask));
      if (w) chk("req_wdata", bus.mem_wdata, lwd);
      chk_busy("req");
      chk("req_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
      chk("req_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
    end
    for (int i = 0; i <= rsp_dly; i++) begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = (i == rsp_dly);
      bus.mem_rdata = (i == rsp_dly) ? rd : $urandom;
      #1;
      chk("wait_mem_valid", 32'(bus.mem_req_valid), 32'd0);
      chk_busy("wait");
      chk("wait_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
      chk("wait_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
    end
    @(negedge clk);
    bus.mem_resp_valid = spur; bus.mem_rdata = $urandom;
    #1;
    chk("resp_ifu_valid", 32'(bus.ifu_resp_valid), 32'(!w));
    chk("resp_lsu_valid", 32'(bus.lsu_resp_valid), 32'(w));
    chk("resp_ifu_rdata", bus.ifu_rdata, w ? 32'd0 : rd);
    chk("resp_lsu_rdata", bus.lsu_rdata, w ? rd : 32'd0);
    chk("resp_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    chk_busy("resp");
  endtask

  initial begin
    bit w;
    bit iv, lv;
    rst = 1'b0;
    drive_idle();

    // Reset state, with requests pending that must not be granted.
    @(negedge clk);
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    #1;
    chk_busy("rst");
    chk("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
    chk("rst_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;

    // Single IFU fetch with exact latency.
    do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 8'h0, 0, 0, 1'b0, 32'h0010_0073, w);

    // Conflict with an LSU store, then serve the loser.
    do_txn(1'b1, 1'b1, 32'h8000_0004, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 0, 0, 1'b0, $urandom, w);
    if (w) do_txn(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 8'h0, 0, 0, 1'b0, $urandom, w);
    else   do_txn(1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 0, 0, 1'b0, $urandom, w);

    // Three back-to-back conflicts.
    repeat (3) do_txn(1'b1, 1'b1, 32'h8000_0010, 32'h8000_2000, 1'b0, $urandom, 8'hFF, 0, 1, 1'b0, $urandom, w);

    // Memory stalls request acceptance for 5 cycles.
    do_txn(1'b0, 1'b1, 32'h0, 32'h8000_3000, 1'b1, 32'h1234_5678, 8'hA5, 5, 2, 1'b0, $urandom, w);

    // Spurious responses while idle, then during REQ/RESP of a real transaction.
    @(negedge clk);
    drive_idle();
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_busy("idle_spur");
      chk("idle_spur_mem_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("idle_spur_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
      chk("idle_spur_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
    end
    do_txn(1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 8'h0, 2, 1, 1'b1, 32'hCAFE_F00D, w);

    // Asynchronous reset while in WAIT.
    @(negedge clk);
    drive_idle();
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0100;
    #1;
    chk("rw_ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    last_lsu = 1'b0;
    @(negedge clk);
    bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1;
    chk("rw_req_valid", 32'(bus.mem_req_valid), 32'd1);
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.lsu_req_valid = 1'b1;
    #1;
    chk("rw_wait_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    #2 rst = 1'b0;
    last_lsu = 1'b1;
    #1;
    chk_busy("rw_rst");
    chk("rw_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rw_rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("rw_rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rw_rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    chk("rw_rst_ifu_rdata", bus.ifu_rdata, 32'd0);
    chk("rw_rst_lsu_rdata", bus.lsu_rdata, 32'd0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rw_in_rst_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rw_post_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
      chk("rw_post_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
      chk("rw_post_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    end
    do_txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 1'b0, 32'h0, 8'h0, 0, 0, 1'b0, 32'h0000_0013, w);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      iv = 1'($urandom);
      lv = 1'($urandom);
      if (!iv && !lv) lv = 1'b1;
      do_txn(iv, lv, $urandom, $urandom, 1'($urandom), $urandom, 8'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), $urandom, w);
    end

    @(negedge clk);
    drive_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
Name: ysyx_24100005_mem_arbiter

Overview:
- Shares the single DPI-backed memory port (npcmem_read/npcmem_write path) between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core.
- Accepts one request at a time from either requester over a valid/ready handshake, and forwards it to the memory port with a registered request.
- Waits for the memory response, then returns the data to the owning requester as a one-cycle pulse.
- Only one transaction is outstanding at any time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte mask width (matches the npcmem_write wmask byte)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  one-cycle pulse, ifu_rdata valid
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  MASK_W  store byte mask
- lsu_resp_valid  out  1  one-cycle pulse: load data valid or store complete
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DATA_W  registered write data
- mem_wmask  out  MASK_W  registered mask; forced to 0 for reads
- mem_resp_valid  in  1  memory response/ack
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- While rst is low: every output is 0, all request registers are 0, and owner = LSU.
- IDLE:
  - ifu_req_ready and lsu_req_ready are driven combinationally; at most one is high, for the winner only.
  - Winner is LSU if both are valid (fixed priority).
  - On a handshake: latch addr, wen, wdata and wmask plus owner. IFU requests latch wen=0 and wmask=0. Go to REQ.
  - With no valid request, stay in IDLE.
- REQ: mem_req_valid=1 and mem_* driven from the latched registers. If mem_req_ready=1, go to WAIT; otherwise hold and keep all mem_* fields stable.
- WAIT: mem_resp_valid is sampled only in this state. When it is 1, capture mem_rdata into the response register and go to RESP.
- RESP:
  - The owner's resp_valid is 1 for exactly one cycle; the other requester's resp_valid is 0.
  - The owner's rdata equals the captured data; the non-owner's rdata is 0.
  - Stores also return the captured data, which carries no meaning.
  - Next state is IDLE.
- Latency: handshake at cycle N; mem_req_valid at N+1; with ready=1 and a response on the next cycle, resp_valid is at N+3. The earliest next acceptance is N+4.
- Both readies are 0 in REQ, WAIT and RESP. Requests arriving then are held by the requester; no queueing.
- mem_resp_valid in IDLE, REQ or RESP is ignored and must not corrupt state.
- Async reset mid-transaction: return to IDLE immediately. No resp pulse is issued and the in-flight transaction is dropped.

Optional Feature:
- Macro: YSYX_24100005_ARB_RR_EN
- Defined: round-robin arbitration.
  - A last_grant register is updated on each handshake and reset to LSU, so the first conflict goes to IFU.
  - On conflict, the grant goes to the requester that was not granted last.
  - A single requester is always granted.
- Undefined: fixed LSU priority; the last_grant register is absent.

Decomposition:
- Shared package: FSM state enum (2-bit), owner encoding (OWNER_IFU=0, OWNER_LSU=1), and ADDR_W/DATA_W/MASK_W defaults.
- Sub-module ysyx_24100005_arb_pick: combinational grant logic.
  - Inputs: two valids, an enable (state==IDLE) and last_grant.
  - Outputs: a one-hot grant.
  - The round-robin path is compiled inside it.

Test Plan:
- Reset release, IFU request addr=0x8000_0000, mem ready=1, resp one cycle later with rdata=0x0010_0073 -> ifu_req_ready at N, mem_req_valid at N+1 with mem_addr=0x8000_0000 and mem_wen=0, ifu_resp_valid=1 at N+3 only with ifu_rdata=0x0010_0073, lsu_resp_valid stays 0.
- IFU and LSU valid in the same cycle (LSU store addr=0x8000_1000, wdata=0xDEADBEEF, wmask=0x0F), macro off -> lsu_req_ready=1 and ifu_req_ready=0; mem_wen=1, mem_wmask=0x0F; IFU is served only after LSU's resp pulse.
- Same conflict repeated three times with the macro on -> grant order IFU, LSU, IFU.
- mem_req_ready held low for 5 cycles -> mem_req_valid and mem_addr/mem_wdata/mem_wmask stay stable, both readies stay 0, WAIT is entered only on the ready cycle.
- Spurious mem_resp_valid in IDLE and REQ -> no resp pulse and no state change.
- rst asserted low while in WAIT -> all outputs 0 immediately, state IDLE, no resp pulse after release; a new IFU request then completes normally.
